// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential signed multiply/divide, one bit per cycle, with divide-by-zero flag
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_q, sa, sb;
  logic [WIDTH-1:0]   mb, abs_a, abs_b, quo, rem;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH:0]     add_sum, shl, diff;
  logic               accept, dz;
  // acc holds {partial/remainder, multiplier/dividend}; mb is the magnitude added or subtracted each step
  always_comb begin
    abs_a   = a[WIDTH-1] ? -a : a;
    abs_b   = b[WIDTH-1] ? -b : b;
    accept  = start && (state == IDLE || state == DONE);
    dz      = op && b == '0;
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
    shl     = acc[2*WIDTH-1:WIDTH-1];
    diff    = shl - {1'b0, mb};
    prod    = (sa ^ sb) ? -acc : acc;
    quo     = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // control FSM with datapath iteration and registered status/result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      cnt      <= '0;
      op_q     <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      mb       <= '0;
      acc      <= '0;
    end else if (accept) begin
      op_q     <= op;
      sa       <= a[WIDTH-1];
      sb       <= b[WIDTH-1];
      mb       <= op ? abs_b : abs_a;
      acc      <= {{WIDTH{1'b0}}, op ? abs_a : abs_b};
      cnt      <= '0;
      div_zero <= dz;
      state    <= dz ? DONE : CALC;
      busy     <= !dz;
      done     <= dz;
    end else if (state == CALC) begin
      acc   <= !op_q ? {add_sum, acc[WIDTH-1:1]} :
               diff[WIDTH] ? {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                             {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      cnt   <= cnt + 1'b1;
      state <= (cnt == CNT_W'(WIDTH - 1)) ? FIX : CALC;
    end else if (state == FIX) begin
      hi    <= op_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo    <= op_q ? quo : prod[WIDTH-1:0];
      state <= DONE;
      busy  <= 1'b0;
      done  <= 1'b1;
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: randomized and directed check of mult_div_seq against a countdown reference model
module tb_mult_div_seq;
  logic        clk = 0, rst = 0, start = 0, op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int          errors = 0, checks = 0;
  bit          chk_en = 0;
  int          m_left = -1;
  logic        m_done = 0, m_dz = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_pend = 0;

  mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_calc(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int q, r;
    if (!o) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    if (x == 32'h8000_0000 && y == 32'hffff_ffff) return {32'h0, 32'h8000_0000};
    q = $signed(x) / $signed(y);
    r = $signed(x) % $signed(y);
    return {r, q};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: a pending operation finishes WIDTH+1 edges after it is accepted
  always @(posedge clk) begin
    if (!rst) begin
      m_left = -1; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1;
          m_left = -1;
        end
      end else if (start) begin
        if (op && b == 0) begin
          m_dz = 1; m_done = 1;
        end else begin
          m_dz = 0; m_left = 33; m_pend = ref_calc(op, a, b);
        end
      end
    end
  end

  // every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("div_zero", {31'b0, div_zero}, {31'b0, m_dz});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, output int k);
    op = o; a = x; b = y; start = 1;
    @(negedge clk);
    start = 0; op = 1'($urandom); a = $urandom; b = $urandom;
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k, n;
    logic o;
    logic [31:0] x, y;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1;
    @(negedge clk);
    run_op(0, 32'd7, 32'hffff_fffd, k);
    chk("mul_lat", k, 34);
    chk("mul_hi", hi, 32'hffff_ffff);
    chk("mul_lo", lo, 32'hffff_ffeb);
    chk("mul_dz", {31'b0, div_zero}, 32'h0);
    run_op(0, 32'h8000_0000, 32'h8000_0000, k);
    chk("mulx_hi", hi, 32'h4000_0000);
    chk("mulx_lo", lo, 32'h0);
    run_op(1, 32'hffff_fff9, 32'd2, k);
    chk("div_lat", k, 34);
    chk("div_lo", lo, 32'hffff_fffd);
    chk("div_hi", hi, 32'hffff_ffff);
    run_op(1, 32'h8000_0000, 32'hffff_ffff, k);
    chk("wrap_lo", lo, 32'h8000_0000);
    chk("wrap_hi", hi, 32'h0);
    run_op(1, 32'h451, 32'h20, k);
    chk("pre_hi", hi, 32'h11);
    chk("pre_lo", lo, 32'h22);
    run_op(1, 32'd5, 32'd0, k);
    chk("dz_lat", k, 1);
    chk("dz_flag", {31'b0, div_zero}, 32'h1);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);
    run_op(1, 32'd100, 32'd7, k);
    chk("dz_clr", {31'b0, div_zero}, 32'h0);
    chk("div2_lo", lo, 32'd14);
    chk("div2_hi", hi, 32'd2);
    repeat (2) @(negedge clk);
    op = 0; a = 3; b = 5; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    op = 0; a = 9; b = 9; start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("one_done", n, 1);
    chk("restart_lo", lo, 32'd15);
    op = 0; a = 32'h1234; b = 32'h5678; start = 1;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("mrst_nodone", n, 0);
    run_op(0, 32'd6, 32'd7, k);
    run_op(1, 32'hffff_ff00, 32'd16, k);
    chk("b2b_lat", k, 34);
    chk("b2b_lo", lo, 32'hffff_fff0);
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom);
      x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 10 : $urandom;
      run_op(o, x, y, k);
      chk("rnd_lat", k, (o && y == 0) ? 1 : 34);
      if (($urandom & 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
